// File: rtl/keypad_scan_fifo.sv
// Row-scanned keypad with per-key debounce feeding a FWFT press/release event FIFO.
// Events are queued the clock after detection; on a full FIFO with no pop they are dropped and overflow latches.
module keypad_scan_fifo #(
  parameter int ROWS           = 5,
  parameter int COLS           = 4,
  parameter int SETTLE_CYCLES  = 1000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int FIFO_DEPTH     = 8,
  parameter int CODE_W         = 5
) (
  input  logic                 clk_100mhz,
  input  logic                 RSTN,
  input  logic [COLS-1:0]      K_COL,
  output logic [ROWS-1:0]      K_ROW,
  output logic                 key_valid,
  input  logic                 key_ready,
  output logic [CODE_W-1:0]    key_code,
  output logic                 key_press,
  output logic [ROWS*COLS-1:0] key_state,
  output logic                 overflow,
  input  logic                 ovf_clr
);
  localparam int NKEYS = ROWS * COLS;
  localparam int SW    = $clog2(SETTLE_CYCLES);
  localparam int DW    = $clog2(DEBOUNCE_SCANS + 1);
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);

  typedef enum logic {ST_SETTLE, ST_EVAL} state_t;

  state_t            state_q, state_d;
  logic [SW-1:0]     cnt_q, cnt_d;
  logic [RW-1:0]     row_q, row_d;
  logic [CW-1:0]     col_q, col_d;
  logic [COLS-1:0]   sample_q, sample_d;
  logic [ROWS-1:0]   krow_q, krow_d;
  logic [DW-1:0]     deb_q [NKEYS];
  logic [DW-1:0]     deb_d [NKEYS];
  logic [NKEYS-1:0]  kstate_q, kstate_d;
  logic [DW-1:0]     deb_inc;
  logic [CODE_W-1:0] key_idx;
  logic              evt_vld, evt_press;

  logic [CODE_W:0]   mem_q [FIFO_DEPTH];
  logic [AW:0]       wptr_q, rptr_q;
  logic              ovf_q, full, push, pop;

  assign key_idx = CODE_W'(int'(row_q) * COLS + int'(col_q));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    row_d     = row_q;
    col_d     = col_q;
    sample_d  = sample_q;
    krow_d    = krow_q;
    deb_d     = deb_q;
    kstate_d  = kstate_q;
    evt_vld   = 1'b0;
    evt_press = 1'b0;
    deb_inc   = deb_q[key_idx] + 1'b1;
    case (state_q)
      ST_SETTLE: begin
        if (cnt_q == SW'(SETTLE_CYCLES - 1)) begin
          sample_d = K_COL;
          cnt_d    = '0;
          col_d    = '0;
          state_d  = ST_EVAL;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_EVAL: begin
        // Column lines are active-low, so an inverted sample is the raw "held" level.
        if (~sample_q[col_q] == kstate_q[key_idx]) begin
          deb_d[key_idx] = '0;
        end else if (deb_inc == DW'(DEBOUNCE_SCANS)) begin
          kstate_d[key_idx] = ~kstate_q[key_idx];
          deb_d[key_idx]    = '0;
          evt_vld           = 1'b1;
          evt_press         = ~kstate_q[key_idx];
        end else begin
          deb_d[key_idx] = deb_inc;
        end
        if (col_q == CW'(COLS - 1)) begin
          row_d   = (row_q == RW'(ROWS - 1)) ? '0 : row_q + 1'b1;
          krow_d  = ~(ROWS'(1) << row_d);
          state_d = ST_SETTLE;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      default: state_d = ST_SETTLE;
    endcase
  end

  always_ff @(posedge clk_100mhz or negedge RSTN) begin
    if (!RSTN) begin
      state_q  <= ST_SETTLE;
      cnt_q    <= '0;
      row_q    <= '0;
      col_q    <= '0;
      sample_q <= '1;
      krow_q   <= ~ROWS'(1);
      kstate_q <= '0;
      for (int i = 0; i < NKEYS; i++) deb_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      row_q    <= row_d;
      col_q    <= col_d;
      sample_q <= sample_d;
      krow_q   <= krow_d;
      kstate_q <= kstate_d;
      deb_q    <= deb_d;
    end
  end

  assign full = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop  = key_valid && key_ready;
  assign push = evt_vld && (!full || pop);

  always_ff @(posedge clk_100mhz or negedge RSTN) begin
    if (!RSTN) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ovf_q  <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[wptr_q[AW-1:0]] <= {evt_press, key_idx};
        wptr_q                <= wptr_q + 1'b1;
      end
      if (pop) rptr_q <= rptr_q + 1'b1;
      if (evt_vld && !push) ovf_q <= 1'b1;
      else if (ovf_clr)     ovf_q <= 1'b0;
    end
  end

  assign K_ROW     = krow_q;
  assign key_valid = (wptr_q != rptr_q);
  assign key_code  = mem_q[rptr_q[AW-1:0]][CODE_W-1:0];
  assign key_press = mem_q[rptr_q[AW-1:0]][CODE_W];
  assign key_state = kstate_q;
  assign overflow  = ovf_q;
endmodule

// File: tb/tb_keypad_scan_fifo.sv
// Scoreboard bench for keypad_scan_fifo: 5x4 keypad, 4-clock settle, 2-scan debounce, 4-deep FIFO.
module tb_keypad_scan_fifo;
  localparam int ROWS = 5, COLS = 4, FRAME = 40;

  logic            clk = 1'b0;
  logic            RSTN = 1'b0;
  logic [COLS-1:0] K_COL;
  logic [ROWS-1:0] K_ROW;
  logic            key_valid, key_ready = 1'b0, key_press, overflow, ovf_clr = 1'b0;
  logic [4:0]      key_code;
  logic [19:0]     key_state;
  logic [ROWS-1:0][COLS-1:0] held = '0;

  int total = 0, bad = 0, cyc = 0;
  logic [5:0] exp_q[$];

  keypad_scan_fifo #(.ROWS(5), .COLS(4), .SETTLE_CYCLES(4), .DEBOUNCE_SCANS(2),
                     .FIFO_DEPTH(4), .CODE_W(5)) dut (
    .clk_100mhz(clk), .RSTN(RSTN), .K_COL(K_COL), .K_ROW(K_ROW),
    .key_valid(key_valid), .key_ready(key_ready), .key_code(key_code),
    .key_press(key_press), .key_state(key_state), .overflow(overflow), .ovf_clr(ovf_clr));

  always #5 clk = ~clk;

  // Board model: a held key pulls its column low while its row is driven.
  always_comb begin
    K_COL = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (!K_ROW[r] && held[r][c]) K_COL[c] = 1'b0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic align();
    while (cyc % FRAME != 0) step(1);
  endtask

  initial begin : monitor
    logic [5:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (RSTN && key_valid && key_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL pop_unexpected: got code=%0d press=%0d expected none", key_code, key_press);
        end else begin
          e = exp_q.pop_front();
          if ({key_press, key_code} !== e) begin
            bad++;
            $display("FAIL pop_event: got code=%0d press=%0d expected code=%0d press=%0d",
                     key_code, key_press, e[4:0], e[5]);
          end
        end
      end
    end
  end

  initial begin : stim
    logic idle_ok;
    logic [4:0] exp_row;
    repeat (3) @(negedge clk);
    chk("reset_krow", 32'(K_ROW), 32'h1E);
    chk("reset_valid", 32'(key_valid), 0);
    chk("reset_code", 32'(key_code), 0);
    chk("reset_ovf", 32'(overflow), 0);
    RSTN = 1'b1;
    cyc  = 0;

    // Idle scan: each row held low for 8 clocks in turn.
    idle_ok = 1'b1;
    for (int n = 0; n <= 200; n++) begin
      exp_row = ~(5'd1 << ((n / 8) % 5));
      chk("idle_krow", 32'(K_ROW), 32'(exp_row));
      if (key_valid !== 1'b0 || key_state !== '0) idle_ok = 1'b0;
      if (n < 200) step(1);
    end
    chk("idle_quiet", 32'(idle_ok), 1);

    // Clean press/release of row2/col1 with consumer ready.
    key_ready = 1'b1;
    held[2][1] = 1'b1;
    exp_q.push_back({1'b1, 5'd9});
    step(3 * FRAME);
    chk("press9_state", 32'(key_state), 32'h200);
    chk("press9_drained", 32'(key_valid), 0);
    held[2][1] = 1'b0;
    exp_q.push_back({1'b0, 5'd9});
    step(3 * FRAME);
    chk("release9_state", 32'(key_state), 0);

    // Single-sample glitch is filtered out.
    held[2][1] = 1'b1;
    step(FRAME);
    held[2][1] = 1'b0;
    step(2 * FRAME);
    chk("glitch_state", 32'(key_state), 0);
    chk("glitch_queue", 32'(exp_q.size()), 0);

    // Keys 0..3 fill the FIFO; key 4 is dropped.
    key_ready = 1'b0;
    held[0] = 4'b1111;
    held[1][0] = 1'b1;
    for (int k = 0; k < 4; k++) exp_q.push_back({1'b1, 5'(k)});
    step(2 * FRAME);
    chk("fill_state", 32'(key_state), 32'h1F);
    chk("fill_ovf", 32'(overflow), 1);
    chk("fill_valid", 32'(key_valid), 1);
    key_ready = 1'b1;
    step(10);
    key_ready = 1'b0;
    chk("fill_drained", 32'(key_valid), 0);
    chk("fill_queue", 32'(exp_q.size()), 0);
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    chk("ovf_clear1", 32'(overflow), 0);
    align();

    // Full FIFO with pop on the same clock as the code-4 release event.
    held = '0;
    for (int k = 0; k < 5; k++) exp_q.push_back({1'b0, 5'(k)});
    step(FRAME + 12);
    chk("full_valid", 32'(key_valid), 1);
    chk("full_ovf_pre", 32'(overflow), 0);
    key_ready = 1'b1;
    step(1);
    key_ready = 1'b0;
    step(2);
    chk("full_ovf_post", 32'(overflow), 0);
    chk("full_state", 32'(key_state), 0);
    key_ready = 1'b1;
    step(10);
    key_ready = 1'b0;
    chk("full_queue", 32'(exp_q.size()), 0);
    chk("full_drained", 32'(key_valid), 0);
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    chk("ovf_clear2", 32'(overflow), 0);
    align();

    // Asynchronous reset during row-1 EVAL with two events queued.
    held[1][0] = 1'b1;
    held[1][1] = 1'b1;
    step(FRAME + 14);
    chk("prerst_valid", 32'(key_valid), 1);
    chk("prerst_state", 32'(key_state), 32'h30);
    chk("prerst_krow", 32'(K_ROW), 32'h1D);
    RSTN = 1'b0;
    #1;
    chk("rst_valid", 32'(key_valid), 0);
    chk("rst_state", 32'(key_state), 0);
    chk("rst_krow", 32'(K_ROW), 32'h1E);
    chk("rst_ovf", 32'(overflow), 0);
    held = '0;
    step(2);
    RSTN = 1'b1;
    cyc = 0;
    step(10);
    chk("postrst_valid", 32'(key_valid), 0);
    chk("end_queue", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/keypad_scan_fifo.md
Name: keypad_scan_fifo

Overview:
- Parametrised matrix-keypad scanner that drives the K_ROW lines and samples the K_COL lines of the board keypad.
- Debounces every key independently and queues press/release events in a small FIFO.
- The game logic pops events through a valid/ready handshake.
- Generalises the fixed 5x4 keypad front end to any ROWS x COLS matrix, with configurable settle time, debounce depth and event buffering.

Parameters:
ROWS, 5, number of row lines driven (K_ROW width)
COLS, 4, number of column lines sampled (K_COL width)
SETTLE_CYCLES, 1000, clocks a row is held low before its columns are sampled (>=2)
DEBOUNCE_SCANS, 4, consecutive disagreeing samples needed to flip a key's stable state (>=1)
FIFO_DEPTH, 8, event queue entries (power of two, >=2)
CODE_W, 5, key-code width; must satisfy 2^CODE_W >= ROWS*COLS

Ports:
clk_100mhz  in   1           system clock
RSTN        in   1           asynchronous active-low reset
K_COL       in   COLS        column sense lines, active-low (0 = pressed on the driven row)
K_ROW       out  ROWS        row drive, one-cold (driven row = 0, others = 1)
key_valid   out  1           FIFO head holds an event
key_ready   in   1           consumer accepts head event when key_valid=1
key_code    out  CODE_W      head event key code = row*COLS + col
key_press   out  1           head event type: 1 = press, 0 = release
key_state   out  ROWS*COLS   debounced level of every key, bit index = key code, 1 = held
overflow    out  1           sticky: an event was dropped because the FIFO was full
ovf_clr     in   1           synchronous clear of overflow

Behaviour:
- Reset (RSTN=0, asynchronous):
  - K_ROW = all ones except bit 0 = 0.
  - FSM = SETTLE, settle counter = 0, row index = 0, column index = 0.
  - All debounce counters = 0, key_state = 0.
  - FIFO empty: key_valid=0, key_code=0, key_press=0.
  - overflow = 0.
  - Reset mid-scan or mid-FIFO discards everything; no event survives.
- FSM:
  - SETTLE: counter increments each clock. At SETTLE_CYCLES-1, latch K_COL into col_sample, clear the counter, set column index = 0, go to EVAL.
  - EVAL: one column per clock, key k = row*COLS + col.
    - If the inverted sample bit equals key_state[k], clear that key's counter.
    - Otherwise increment the counter. When the incremented value reaches DEBOUNCE_SCANS, toggle key_state[k], clear the counter, and emit event {code=k, press=new level} that cycle.
    - At col = COLS-1: advance row (wrap ROWS-1 -> 0), update K_ROW the next clock, return to SETTLE.
  - Frame period = ROWS*(SETTLE_CYCLES+COLS) clocks.
  - Since at most one key is evaluated per clock, at most one event is generated per clock, including simultaneous multi-key changes.
- Debounce latency: a clean level change is reflected in key_state DEBOUNCE_SCANS samples of that key after the first disagreeing sample (DEBOUNCE_SCANS frames). A bounce that reverts before then produces no event.
- FIFO (first-word-fall-through):
  - key_valid = not empty. key_code/key_press show the head combinationally from registered storage.
  - Pop when key_valid & key_ready.
  - Push when an event occurs and (not full, or pop in the same cycle). Full with a simultaneous pop accepts the push.
  - Empty with a simultaneous push: key_valid rises the next clock; the event is not bypassed.
  - Pointers are CLOG2(FIFO_DEPTH)+1 bits and wrap naturally.
  - Event on full with no pop: event dropped, overflow set next clock. key_state still updates.
  - Set has priority over ovf_clr in the same cycle.
- key_ready while key_valid=0 has no effect. Contents of key_code/key_press while key_valid=0 are don't-care (hold the last head).

Test Plan (ROWS=5, COLS=4, SETTLE_CYCLES=4, DEBOUNCE_SCANS=2, FIFO_DEPTH=4, 40-clock frame):
- Reset, K_COL=4'b1111 held 200 clocks -> K_ROW cycles 11110, 11101, 11011, 10111, 01111, each held 8 clocks; key_valid=0, key_state=0.
- Hold key row2/col1 (K_COL[1]=0 whenever K_ROW[2]=0) for 3 frames, ready=1 -> one event code=9 press=1 after the 2nd sample; key_state[9]=1. Release -> one event code=9 press=0.
- Glitch row2/col1 for a single sample, then clean -> no event, key_state[9] stays 0.
- Press keys 0, 1, 2, 3 together (row0, K_COL=0000), ready=0 -> codes 0, 1, 2, 3 queued on consecutive EVAL clocks. A further press of code 4 -> dropped, overflow=1. Pop all -> order 0, 1, 2, 3.
- FIFO full with key_ready=1 on the same clock as a new event -> push accepted, occupancy stays 4, overflow stays 0. Then ovf_clr=1 with no event -> overflow=0.
- Assert RSTN=0 mid-EVAL with 2 queued events -> key_valid=0, key_state=0 and K_ROW=11110 immediately (asynchronous).
